// File: rtl/keylock_pkg.sv
// keylock_pkg: key codes, controller states and key classification shared by the lock
package keylock_pkg;
  localparam logic [3:0] KEY_ENTER = 4'hA;
  localparam logic [3:0] KEY_CLEAR = 4'hB;
  typedef enum logic [2:0] {IDLE, ENTRY, CHECK, OPEN, PROG_SLOT, PROG_NEW, PROG_CONF, LOCKOUT} state_t;
  function automatic logic is_digit(input logic [3:0] k);
    return k <= 4'd9;
  endfunction
endpackage

// File: rtl/keylock_if.sv
// keylock_if: key strobe from the scanner and lock status/pulses to the actuator side
interface keylock_if #(parameter int DIGITS = 6, parameter int MAX_FAIL = 3);
  logic key_valid;
  logic [3:0] key;
  logic unlocked, prog_mode, locked_out, ok_pulse, err_pulse;
  logic [$clog2(MAX_FAIL+1)-1:0] fail_count;
  logic [$clog2(DIGITS+1)-1:0] digit_count;
  modport master(output key_valid, key, input unlocked, prog_mode, locked_out, ok_pulse, err_pulse, fail_count, digit_count);
  modport slave(input key_valid, key, output unlocked, prog_mode, locked_out, ok_pulse, err_pulse, fail_count, digit_count);
endinterface

// File: rtl/code_entry.sv
// code_entry: digit shift buffer with count, CLEAR handling and key-idle timeout counter
module code_entry import keylock_pkg::*; #(
  parameter int DIGITS = 6,
  parameter int TIMEOUT_CYCLES = 60000000
) (
  input  logic hwclk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  input  logic run,
  input  logic key_valid,
  input  logic [3:0] key,
  output logic [4*DIGITS-1:0] code_buf,
  output logic [$clog2(DIGITS+1)-1:0] digit_count,
  output logic full,
  output logic timeout
);
  localparam int CW = $clog2(DIGITS+1);
  localparam int TW = $clog2(TIMEOUT_CYCLES+1);
  logic [TW-1:0] idle_cnt;
  assign full = digit_count == CW'(DIGITS);
  assign timeout = idle_cnt == TW'(TIMEOUT_CYCLES-1);
  always_ff @(posedge hwclk) begin
    if (reset || clr || (en && key_valid && key == KEY_CLEAR)) begin
      code_buf <= '0;
      digit_count <= '0;
    end else if (en && key_valid && is_digit(key) && !full) begin
      code_buf <= {code_buf[4*DIGITS-5:0], key};
      digit_count <= digit_count + CW'(1);
    end
    idle_cnt <= (reset || !run || key_valid) ? '0 : idle_cnt + TW'(!timeout);
  end
endmodule

// File: rtl/keylock_core.sv
// keylock_core: keypad lock FSM with user-code slots, master programming, lockout and auto-relock
module keylock_core import keylock_pkg::*; #(
  parameter int DIGITS = 6,
  parameter int SLOTS = 2,
  parameter int MAX_FAIL = 3,
  parameter int LOCKOUT_CYCLES = 120000000,
  parameter int TIMEOUT_CYCLES = 60000000,
  parameter int OPEN_CYCLES = 60000000,
  parameter logic [4*DIGITS-1:0] MASTER_CODE = 24'h555116,
  parameter logic [4*DIGITS-1:0] INIT_CODE = 24'h666666
) (
  input logic hwclk,
  input logic reset,
  keylock_if.slave bus
);
  localparam int FW = $clog2(MAX_FAIL+1);
  localparam int SW = SLOTS > 1 ? $clog2(SLOTS) : 1;
  localparam int TMAX = LOCKOUT_CYCLES > OPEN_CYCLES ? LOCKOUT_CYCLES : OPEN_CYCLES;
  localparam int TW = $clog2(TMAX+1);
  state_t state, nxt;
  logic [4*DIGITS-1:0] code_buf, cand;
  logic [4*DIGITS-1:0] slot_code [SLOTS];
  logic [SLOTS-1:0] slot_valid, slot_hit;
  logic [SW-1:0] sel;
  logic [FW-1:0] fail_count, fail_nxt, fail_inc;
  logic [TW-1:0] tmr;
  logic full, timeout, clr, ok, err, wr, cand_ld, sel_ld;
  logic dig, ent, clrk, master_hit, code_hit, last_fail;
  code_entry #(.DIGITS(DIGITS), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_entry (
    .hwclk, .reset, .clr,
    .en(state inside {IDLE, ENTRY, PROG_NEW, PROG_CONF}),
    .run(state inside {ENTRY, PROG_SLOT, PROG_NEW, PROG_CONF}),
    .key_valid(bus.key_valid), .key(bus.key),
    .code_buf, .digit_count(bus.digit_count), .full, .timeout
  );
  for (genvar g = 0; g < SLOTS; g++) assign slot_hit[g] = slot_valid[g] && slot_code[g] == code_buf;
  assign dig = bus.key_valid && is_digit(bus.key);
  assign ent = bus.key_valid && bus.key == KEY_ENTER;
  assign clrk = bus.key_valid && bus.key == KEY_CLEAR;
  assign master_hit = full && code_buf == MASTER_CODE;
  assign code_hit = full && |slot_hit;
  assign last_fail = fail_count >= FW'(MAX_FAIL-1);
  assign fail_inc = fail_count + FW'(fail_count != FW'(MAX_FAIL));
  assign bus.unlocked = state == OPEN;
  assign bus.prog_mode = state inside {PROG_SLOT, PROG_NEW, PROG_CONF};
  assign bus.locked_out = state == LOCKOUT;
  assign bus.fail_count = fail_count;
  always_comb begin
    nxt = state;
    fail_nxt = fail_count;
    {clr, ok, err, wr, cand_ld, sel_ld} = '0;
    case (state)
      IDLE: nxt = dig ? ENTRY : IDLE;
      ENTRY: begin
        clr = timeout;
        nxt = timeout ? IDLE : ent ? CHECK : ENTRY;
      end
      CHECK: begin
        clr = 1'b1;
        ok = !master_hit && code_hit;
        err = !master_hit && !code_hit;
        fail_nxt = ok ? '0 : err ? fail_inc : fail_count;
        nxt = master_hit ? PROG_SLOT : ok ? OPEN : last_fail ? LOCKOUT : IDLE;
      end
      OPEN: nxt = (bus.key_valid || tmr == TW'(OPEN_CYCLES-1)) ? IDLE : OPEN;
      PROG_SLOT: begin
        sel_ld = !timeout && dig && int'(bus.key) < SLOTS;
        err = !timeout && !sel_ld && (dig || ent || clrk);
        nxt = sel_ld ? PROG_NEW : (timeout || err) ? IDLE : PROG_SLOT;
      end
      PROG_NEW: begin
        clr = timeout || ent;
        cand_ld = !timeout && ent && full;
        err = !timeout && ent && !full;
        nxt = cand_ld ? PROG_CONF : (timeout || err) ? IDLE : PROG_NEW;
      end
      PROG_CONF: begin
        clr = timeout || ent;
        wr = !timeout && ent && full && code_buf == cand;
        ok = wr;
        err = !timeout && ent && !wr;
        nxt = clr ? IDLE : PROG_CONF;
      end
      LOCKOUT: begin
        nxt = tmr == TW'(LOCKOUT_CYCLES-1) ? IDLE : LOCKOUT;
        fail_nxt = nxt == IDLE ? '0 : fail_count;
      end
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge hwclk) begin
    if (reset) begin
      state <= IDLE;
      fail_count <= '0;
      tmr <= '0;
      sel <= '0;
      cand <= '0;
      bus.ok_pulse <= 1'b0;
      bus.err_pulse <= 1'b0;
      slot_valid <= SLOTS'(1);
      for (int i = 0; i < SLOTS; i++) slot_code[i] <= i == 0 ? INIT_CODE : '0;
    end else begin
      state <= nxt;
      fail_count <= fail_nxt;
      tmr <= (nxt != state) ? '0 : tmr + TW'(tmr != TW'(TMAX));
      cand <= cand_ld ? code_buf : (nxt == IDLE) ? '0 : cand;
      bus.ok_pulse <= ok;
      bus.err_pulse <= err;
      if (sel_ld) sel <= SW'(bus.key);
      if (wr) begin
        slot_code[sel] <= code_buf;
        slot_valid[sel] <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_keylock_core.sv
// tb_keylock_core: randomized key stimulus, queue-based lock model and pulse scoreboard
module tb_keylock_core;
  localparam int LOCK_C = 50, TOUT_C = 40, OPEN_C = 30, SLOTS = 2;
  localparam logic [23:0] MASTER = 24'h555116, INIT = 24'h666666;
  typedef enum int {M_IDLE, M_ENTRY, M_OPEN, M_SEL, M_NEW, M_CONF, M_LOCK} mode_t;
  typedef struct {bit ok; int due; int fails; bit unl; bit lock; bit prog;} exp_t;
  logic hwclk = 0, reset = 1;
  int cyc = 0, errors = 0, checks = 0;
  mode_t mode;
  int dq[$];
  logic [23:0] sc [SLOTS];
  bit sv [SLOTS];
  int fails, sel;
  logic [23:0] cand;
  exp_t expq[$];
  exp_t e;
  keylock_if #(.DIGITS(6), .MAX_FAIL(3)) bus ();
  keylock_core #(.LOCKOUT_CYCLES(LOCK_C), .TIMEOUT_CYCLES(TOUT_C), .OPEN_CYCLES(OPEN_C)) dut (.hwclk(hwclk), .reset(reset), .bus(bus));
  always #5 hwclk = ~hwclk;
  always @(posedge hwclk) cyc++;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [23:0] dq_code();
    logic [23:0] v = 0;
    foreach (dq[i]) v = {v[19:0], 4'(dq[i])};
    return v;
  endfunction

  function automatic logic [23:0] rand_code();
    logic [23:0] v = 0;
    for (int i = 0; i < 6; i++) v = {v[19:0], 4'($urandom_range(0, 9))};
    return v;
  endfunction

  function automatic logic [23:0] pick_slot();
    int v[$];
    foreach (sv[i]) if (sv[i]) v.push_back(i);
    return sc[v[$urandom_range(0, v.size() - 1)]];
  endfunction

  task automatic model_reset();
    mode = M_IDLE;
    dq.delete();
    expq.delete();
    sc[0] = INIT; sc[1] = 0;
    sv[0] = 1; sv[1] = 0;
    fails = 0; sel = 0; cand = 0;
  endtask

  task automatic expect_pulse(input bit ok, input int lat);
    expq.push_back('{ok, cyc + lat, fails, mode == M_OPEN, mode == M_LOCK, mode inside {M_SEL, M_NEW, M_CONF}});
  endtask

  task automatic model_key(input int k);
    logic [23:0] code = dq_code();
    bit full = dq.size() == 6;
    bit hit = 0;
    if (mode == M_LOCK) return;
    if (mode == M_OPEN) begin mode = M_IDLE; return; end
    if (mode == M_SEL) begin
      if (k < SLOTS) begin sel = k; mode = M_NEW; end
      else if (k <= 11) begin mode = M_IDLE; expect_pulse(0, 1); end
      return;
    end
    if (k <= 9) begin
      if (mode == M_IDLE) mode = M_ENTRY;
      if (!full) dq.push_back(k);
      return;
    end
    if (mode == M_IDLE || k > 11) return;
    dq.delete();
    if (k == 11) return;
    if (mode == M_ENTRY) begin
      foreach (sv[i]) hit |= full && sv[i] && sc[i] == code;
      if (full && code == MASTER) mode = M_SEL;
      else if (hit) begin mode = M_OPEN; fails = 0; expect_pulse(1, 2); end
      else begin fails++; mode = fails >= 3 ? M_LOCK : M_IDLE; expect_pulse(0, 2); end
    end else if (mode == M_NEW) begin
      if (full) begin cand = code; mode = M_CONF; end
      else begin mode = M_IDLE; expect_pulse(0, 1); end
    end else begin
      mode = M_IDLE;
      if (full && code == cand) begin sc[sel] = code; sv[sel] = 1; expect_pulse(1, 1); end
      else expect_pulse(0, 1);
    end
  endtask

  task automatic check_levels();
    chk("unlocked", bus.unlocked, mode == M_OPEN);
    chk("locked_out", bus.locked_out, mode == M_LOCK);
    chk("prog_mode", bus.prog_mode, mode inside {M_SEL, M_NEW, M_CONF});
    chk("fail_count", bus.fail_count, fails);
    chk("digit_count", bus.digit_count, dq.size());
  endtask

  task automatic press(input int k);
    @(negedge hwclk);
    bus.key_valid = 1;
    bus.key = 4'(k);
    model_key(k);
    @(negedge hwclk);
    bus.key_valid = 0;
    repeat (2) @(negedge hwclk);
    check_levels();
  endtask

  task automatic press_digits(input logic [23:0] c, input int n);
    for (int i = 0; i < n; i++) press(int'(c[4*(n-1-i) +: 4]));
  endtask

  task automatic enter_code(input logic [23:0] c);
    press_digits(c, 6);
    press(10);
  endtask

  task automatic wait_idle(input int n);
    repeat (n) @(negedge hwclk);
    if (n > TOUT_C + 4 && mode inside {M_ENTRY, M_SEL, M_NEW, M_CONF}) begin mode = M_IDLE; dq.delete(); end
    if (n > OPEN_C + 4 && mode == M_OPEN) mode = M_IDLE;
    if (n > LOCK_C + 4 && mode == M_LOCK) begin mode = M_IDLE; fails = 0; end
    check_levels();
  endtask

  task automatic do_reset();
    @(negedge hwclk);
    reset = 1;
    bus.key_valid = 0;
    @(negedge hwclk);
    reset = 0;
    model_reset();
    chk("reset_ok_pulse", bus.ok_pulse, 0);
    chk("reset_err_pulse", bus.err_pulse, 0);
    check_levels();
  endtask

  always @(negedge hwclk) begin
    if (!reset && (bus.ok_pulse || bus.err_pulse)) begin
      if (expq.size() == 0) chk("pulse_unexpected", {bus.ok_pulse, bus.err_pulse}, 0);
      else begin
        e = expq.pop_front();
        chk("pulse_cycle", cyc, e.due);
        chk("pulse_kind", {bus.ok_pulse, bus.err_pulse}, e.ok ? 2 : 1);
        chk("pulse_fail_count", bus.fail_count, e.fails);
        chk("pulse_unlocked", bus.unlocked, e.unl);
        chk("pulse_locked_out", bus.locked_out, e.lock);
        chk("pulse_prog_mode", bus.prog_mode, e.prog);
      end
    end else if (expq.size() != 0 && expq[0].due < cyc) begin
      chk("pulse_missing", cyc, expq[0].due);
      void'(expq.pop_front());
    end
  end

  initial begin
    int r;
    bus.key_valid = 0;
    bus.key = 0;
    do_reset();
    enter_code(24'h666666);
    press(3);
    repeat (3) enter_code(24'h123456);
    enter_code(24'h666666);
    wait_idle(60);
    enter_code(24'h666666);
    press(0);
    enter_code(MASTER);
    press(1);
    enter_code(24'h123456);
    enter_code(24'h123456);
    enter_code(24'h123456);
    press(12);
    enter_code(24'h666666);
    wait_idle(60);
    do_reset();
    enter_code(MASTER);
    press(1);
    enter_code(24'h123456);
    enter_code(24'h123457);
    enter_code(24'h123456);
    enter_code(MASTER);
    press(7);
    press_digits(24'h666666, 6);
    press(6);
    press(10);
    press(11);
    press_digits(24'h000123, 3);
    wait_idle(60);
    enter_code(MASTER);
    press(1);
    enter_code(24'h123456);
    press_digits(24'h000123, 3);
    do_reset();
    enter_code(24'h123456);
    for (int it = 0; it < 300; it++) begin
      r = $urandom_range(0, 9);
      case (mode)
        M_LOCK: begin
          repeat ($urandom_range(0, 2)) press($urandom_range(0, 15));
          wait_idle(60);
        end
        M_OPEN: if (r < 7) press($urandom_range(0, 15)); else wait_idle(60);
        M_SEL: press(r < 7 ? $urandom_range(0, 1) : $urandom_range(0, 15));
        M_NEW: begin press_digits(rand_code(), r < 8 ? 6 : $urandom_range(1, 5)); press(10); end
        M_CONF: begin press_digits(r < 6 ? cand : rand_code(), 6); press(10); end
        default: begin
          if (r < 4) enter_code(pick_slot());
          else if (r == 4) enter_code(rand_code());
          else if (r == 5) enter_code(MASTER);
          else if (r == 6) begin press_digits(rand_code(), $urandom_range(1, 5)); press(10); end
          else if (r == 7) press($urandom_range(0, 15));
          else if (r == 8) press(11);
          else wait_idle(60);
        end
      endcase
    end
    repeat (5) @(negedge hwclk);
    chk("queue_drained", expq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/keylock_core.md
Name: keylock_core

Overview:
Parametrised keypad lock controller. It replaces the single-code, single-slot check/confirm flow with an N-digit code buffer, multiple user-code slots, master-code programming with confirm, failed-attempt lockout, entry timeout and auto-relock. It consumes debounced key events from the keypad scanner and drives the lock/LED/pattern logic through status levels and one-cycle pulses.

Parameters:
DIGITS, 6, digits per code.
SLOTS, 2, number of user-code slots.
MAX_FAIL, 3, consecutive failed attempts before lockout.
LOCKOUT_CYCLES, 120000000, lockout duration in hwclk cycles (10 s at 12 MHz).
TIMEOUT_CYCLES, 60000000, idle-key timeout during entry or programming.
OPEN_CYCLES, 60000000, auto-relock delay.
MASTER_CODE, 24'h555116, programming code, 4 bits per digit, MS digit first.
INIT_CODE, 24'h666666, reset value of slot 0.

Ports:
hwclk  in  1  system clock, 12 MHz.
reset  in  1  synchronous, active-high reset.
key_valid  in  1  one-cycle strobe, key accepted this cycle.
key  in  4  0-9 digit, 4'hA ENTER, 4'hB CLEAR, others ignored.
unlocked  out  1  level, lock open.
prog_mode  out  1  level, in any PROG state.
locked_out  out  1  level, in LOCKOUT.
ok_pulse  out  1  one cycle on successful unlock or slot write.
err_pulse  out  1  one cycle on any rejected attempt or abort by error.
fail_count  out  $clog2(MAX_FAIL+1)  consecutive failures.
digit_count  out  $clog2(DIGITS+1)  digits currently buffered.

Behaviour:
- Reset: state IDLE; all outputs 0; buffer cleared; slot0=INIT_CODE valid; other slots invalid; timers 0.
- States: IDLE, ENTRY, CHECK, OPEN, PROG_SLOT, PROG_NEW, PROG_CONF, LOCKOUT.
- Buffer: digit key shifts left by 4 bits, digit_count++. Digit when digit_count==DIGITS is ignored (no shift). CLEAR empties the buffer and stays in the current state.
- IDLE: first digit goes to ENTRY. ENTER or CLEAR in IDLE is ignored.
- ENTRY: ENTER goes to CHECK. Invalid keys (C-F) are ignored.
- CHECK, one cycle: if digit_count!=DIGITS it is a fail. Else the buffer is compared in parallel against MASTER_CODE and every valid slot.
  - Master match: go to PROG_SLOT.
  - Slot match: go to OPEN, ok_pulse, fail_count=0.
  - Otherwise: err_pulse, fail_count++. Go to LOCKOUT if fail_count reaches MAX_FAIL, else IDLE.
  - Buffer is cleared on exit.
- CHECK latency: ENTER strobe at cycle N; CHECK at N+1; state, pulses and unlocked valid at N+2. key_valid during CHECK is dropped.
- OPEN: unlocked=1. Any key or OPEN_CYCLES elapsed goes to IDLE with unlocked=0 on the next cycle. The relocking key is consumed.
- PROG_SLOT: digit d<SLOTS selects slot d and goes to PROG_NEW. d>=SLOTS, ENTER or CLEAR gives err_pulse and goes to IDLE.
- PROG_NEW: collect code. ENTER with digit_count==DIGITS latches the candidate and goes to PROG_CONF. ENTER with a short count gives err_pulse and goes to IDLE.
- PROG_CONF: collect again. ENTER with a full buffer equal to the candidate writes the slot, sets it valid, gives ok_pulse and goes to IDLE. Mismatch or short count gives err_pulse, no write, IDLE. CLEAR in PROG_NEW/PROG_CONF only empties the buffer.
- Programming failures never increment fail_count.
- Timeout: in ENTRY, PROG_SLOT, PROG_NEW and PROG_CONF, the counter resets on every key_valid. At TIMEOUT_CYCLES: go to IDLE, clear buffer and candidate, no pulse, no fail increment.
- LOCKOUT: locked_out=1. All keys are ignored and do not restart the timer. After LOCKOUT_CYCLES: fail_count=0, go to IDLE.
- Writing a code equal to an existing slot or to MASTER_CODE is legal. Master match takes priority in CHECK.
- reset asserted in any state, including mid-write or mid-lockout, restores reset values at the next edge. Programmed slots are lost.
- Counters saturate; they never wrap.

Decomposition:
- keylock_pkg: KEY_ENTER=4'hA, KEY_CLEAR=4'hB, state enum, and a function is_digit(key).
- Sub-module code_entry: shift buffer, digit_count, CLEAR handling and idle-timeout counter. Its outputs are buf, full and timeout.
- keylock_core holds the FSM, slot RAM (registers), candidate register and lockout/open timers.

Test Plan:
1. Keys 6,6,6,6,6,6,ENTER: ok_pulse 2 cycles after ENTER, unlocked=1, fail_count=0. Any key then gives unlocked=0 next cycle.
2. Three wrong codes (1,2,3,4,5,6,ENTER x3): err_pulse x3, then locked_out=1. Correct code during lockout is ignored. After LOCKOUT_CYCLES (use small override), locked_out=0, fail_count=0, and the correct code unlocks.
3. Master 5,5,5,1,1,6,ENTER; 1; 1,2,3,4,5,6,ENTER; 1,2,3,4,5,6,ENTER: ok_pulse. Code 123456 then unlocks and 666666 still unlocks.
4. Programming with a confirm mismatch (123456 then 123457): err_pulse, slot1 stays invalid, 123456 fails with fail_count=1.
5. Master, then slot digit 7 (SLOTS=2): err_pulse, IDLE, prog_mode=0. Seven digits then ENTER: 7th ignored, digit_count=6, correct 6-digit prefix unlocks.
6. Three digits then silence for TIMEOUT_CYCLES: digit_count=0, IDLE, no pulse, fail_count unchanged. reset asserted in PROG_CONF: all outputs 0 next cycle, slot1 invalid.
